dmem_responder: RTL and testbench

Data-memory responder serving the CPU's load/store port through a valid/ready request–response handshake with a configurable number of wait states. It holds a word-addressed storage array, supports byte-enabled writes, and flags misaligned or out-of-range accesses. It replaces the zero-latency data memory so the datapath can be exercised against realistic memory timing.

---
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request/response with WAIT wait states,
// byte-enabled stores into a word array, and misaligned/out-of-range flagging.
module dmem_responder #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [3:0]    req_be,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          lat_write;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [3:0]    lat_be;

  logic [DW-1:0] mem [DEPTH];

  logic          acc_go;
  logic          acc_write;
  logic          acc_err;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic [3:0]    acc_be;
  logic [IW-1:0] acc_idx;
  logic [DW-1:0] rdata_nxt;

  assign req_ready = (state == S_IDLE) & rst;

  // With WAIT = 0 the access happens on the acceptance edge, so it must use
  // the live request rather than the (not yet loaded) latched copy.
  always_comb begin
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    acc_be    = lat_be;
    if (state == S_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
    acc_go    = rst & (((state == S_IDLE) & req_valid & (WAIT == 0)) |
                       ((state == S_WAIT) & (cnt == '0)));
    acc_err   = (acc_addr[1:0] != 2'b00) |
                ({2'b00, acc_addr[AW-1:2]} >= AW'(DEPTH));
    acc_idx   = acc_addr[IW+1:2];
    rdata_nxt = (acc_err | acc_write) ? '0 : mem[acc_idx];
  end

  always_ff @(posedge clk) begin
    if (acc_go && acc_write && !acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            if (WAIT == 0) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rdata_nxt;
              rsp_err   <= acc_err;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_nxt;
            rsp_err   <= acc_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, multi-cycle corner sequences and
// randomized traffic against a byte-array memory model, on WAIT=2 and WAIT=3.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, req_write, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        rr2, rv2, re2, rr3, rv3, re3;
  logic [31:0] rd2, rd3;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mb [2][1024];

  always #5 clk = ~clk;

  dmem_responder #(.AW(32), .DW(32), .DEPTH(256), .WAIT(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(rr2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv2), .rsp_ready(rsp_ready | sel), .rsp_rdata(rd2), .rsp_err(re2)
  );

  dmem_responder #(.AW(32), .DW(32), .DEPTH(256), .WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(rr3),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv3), .rsp_ready(rsp_ready | ~sel), .rsp_rdata(rd3), .rsp_err(re3)
  );

  assign req_ready = sel ? rr3 : rr2;
  assign rsp_valid = sel ? rv3 : rv2;
  assign rsp_rdata = sel ? rd3 : rd2;
  assign rsp_err   = sel ? re3 : re2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model as a flat byte array; errors from plain address arithmetic.
  function automatic void ref_access(input int s, input bit w, input logic [31:0] a,
                                     input logic [31:0] d, input logic [3:0] be,
                                     output logic [31:0] rd, output logic er);
    er = (a % 4 != 0) || (a / 4 >= 256);
    rd = '0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mb[s][int'(a) + i] = d[8*i +: 8];
      end else begin
        rd = {mb[s][int'(a) + 3], mb[s][int'(a) + 2], mb[s][int'(a) + 1], mb[s][int'(a)]};
      end
    end
  endfunction

  // Entered and left at posedge+1; hold = extra cycles rsp_ready stays low.
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    int k;
    req_write = w; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_valid_timeout: got 0 expected 1");
    end
    rd = rsp_rdata;
    er = rsp_err;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_after_consume", rsp_valid, 0);
  endtask

  task automatic abort_store();
    bit seen;
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_in_reset", req_ready, 0);
    chk("valid_in_reset", rsp_valid, 0);
    rst = 1'b1;
    #1;
    chk("ready_after_reset", req_ready, 1);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_abort", seen, 0);
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  initial begin
    vec_t        tbl[11];
    logic [31:0] rd, mrd;
    logic        er, mer;
    int          lat;

    sel = 1'b0; rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst = 1'b1;
    #1;
    chk("post_rst_req_ready", req_ready, 1);

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int wd = 0; wd < 16; wd++) begin
        logic [31:0] v;
        v = $urandom;
        txn(1'b1, 32'(wd * 4), v, 4'hF, 0, rd, er, lat);
        ref_access(s, 1'b1, 32'(wd * 4), v, 4'hF, mrd, mer);
      end
    end
    sel = 1'b0;

    tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h10,  32'h00005500, 4'b0010, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 32'h10,  32'h0,        4'b1111, 32'hDEAD55EF, 1'b0};
    tbl[4]  = '{1'b1, 32'h12,  32'hFFFFFFFF, 4'b1111, 32'h0,        1'b1};
    tbl[5]  = '{1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEAD55EF, 1'b0};
    tbl[6]  = '{1'b1, 32'h3FC, 32'h0BADF00D, 4'b1111, 32'h0,        1'b0};
    tbl[7]  = '{1'b0, 32'h400, 32'h0,        4'b0000, 32'h0,        1'b1};
    tbl[8]  = '{1'b0, 32'h3FC, 32'h0,        4'b0000, 32'h0BADF00D, 1'b0};
    tbl[9]  = '{1'b1, 32'h10,  32'h0,        4'b0000, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEAD55EF, 1'b0};

    for (int i = 0; i < 11; i++) begin
      txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, i % 3, rd, er, lat);
      ref_access(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, mrd, mer);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), er, tbl[i].exp_err);
      chk($sformatf("tbl%0d_latency", i), lat, 2);
    end

    // Backpressure with req_valid held high through RESP.
    ref_access(0, 1'b0, 32'h10, 32'h0, 4'h0, mrd, mer);
    req_write = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h14;
    @(posedge clk); #1;
    chk("bp_not_yet_valid", rsp_valid, 0);
    @(posedge clk); #1;
    chk("bp_valid", rsp_valid, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_valid", c), rsp_valid, 1);
      chk($sformatf("bp_hold%0d_rdata", c), rsp_rdata, mrd);
      chk($sformatf("bp_hold%0d_err", c), rsp_err, 0);
      chk($sformatf("bp_hold%0d_ready", c), req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_consumed_valid", rsp_valid, 0);
    chk("bp_ready_back", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_second_accepted", req_ready, 0);
    ref_access(0, 1'b0, 32'h14, 32'h0, 4'h0, mrd, mer);
    @(posedge clk); #1;
    chk("bp_second_early", rsp_valid, 0);
    @(posedge clk); #1;
    chk("bp_second_valid", rsp_valid, 1);
    chk("bp_second_rdata", rsp_rdata, mrd);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset during WAIT on the WAIT=3 instance.
    sel = 1'b1;
    #1;
    abort_store();
    txn(1'b1, 32'h20, 32'hAAAAAAAA, 4'hF, 0, rd, er, lat);
    ref_access(1, 1'b1, 32'h20, 32'hAAAAAAAA, 4'hF, mrd, mer);
    chk("w3_store_latency", lat, 3);
    abort_store();
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
    chk("w3_abort_load", rd, 32'hAAAAAAAA);
    chk("w3_abort_err", er, 0);

    for (int n = 0; n < 200; n++) begin
      int unsigned r;
      bit          w;
      logic [31:0] a, d;
      logic [3:0]  be;
      int          s;
      s = (n < 150) ? 0 : 1;
      sel = s[0];
      #1;
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 1) a = ($urandom_range(0, 1) == 0) ? 32'(32'h400 + $urandom_range(0, 255) * 4)
                                                       : 32'hFFFF_FFFC;
      else             a = 32'($urandom_range(0, 15) * 4);
      w  = $urandom_range(0, 1) == 1;
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      txn(w, a, d, be, $urandom_range(0, 3), rd, er, lat);
      ref_access(s, w, a, d, be, mrd, mer);
      chk($sformatf("rnd%0d_rdata a=%h w=%0d", n, a, w), rd, mrd);
      chk($sformatf("rnd%0d_err a=%h", n, a), er, mer);
      chk($sformatf("rnd%0d_latency", n), lat, s + 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
